// File: rtl/sine_sched_pkg.sv
// rtl/sine_sched_pkg.sv - shared types, default widths and phase offsets for the sine LUT scheduler
//
// Purpose : FSM state encoding, default parameter widths and the 120/240 degree
//           address offsets, derived from the ROM address width.
// Ports   : none (package)
// Config  : optional phase_sync feature is selected by `SINE_PHASE_SYNC_EN
//           in the modules that import this package.

package sine_sched_pkg;

  localparam int PHASE_W_DEF = 32;
  localparam int ADDR_W_DEF  = 16;
  localparam int DATA_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_A = 2'd1,
    RD_B = 2'd2,
    RD_C = 2'd3
  } state_t;

  // One third of the ROM address space, truncated: 0x5555 for a 16-bit address.
  function automatic logic [31:0] ofs_b(input int addr_w);
    logic [63:0] full;
    full = (64'd1 << addr_w) / 64'd3;
    return full[31:0];
  endfunction

  // Two thirds of the address space is exactly twice the truncated third (0xAAAA).
  function automatic logic [31:0] ofs_c(input int addr_w);
    return ofs_b(addr_w) << 1;
  endfunction

endpackage

// File: rtl/sine_phase_acc.sv
// rtl/sine_phase_acc.sv - DDS phase accumulator with tuning word register and optional phase sync
//
// Purpose : holds tw_active and phase_acc; advances once per accepted tick and
//           presents the channel A ROM address for the round being started.
// Ports   : clk, rst        - clock, synchronous active-high reset
//           phase_sync      - (only with `SINE_PHASE_SYNC_EN) pulse that requests
//                             a restart from phase 0 at the next advance
//           tuning_word     - new phase increment
//           tw_load         - pulse: latch tuning_word into tw_active
//           advance         - pulse: a round is starting, step the accumulator
//           addr_a          - channel A address for the round starting on advance
// Config  : `SINE_PHASE_SYNC_EN adds the phase_sync input and pending flag.

module sine_phase_acc
  import sine_sched_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
`ifdef SINE_PHASE_SYNC_EN
  input  logic               phase_sync,
`endif
  input  logic [PHASE_W-1:0] tuning_word,
  input  logic               tw_load,
  input  logic               advance,
  output logic [ADDR_W-1:0]  addr_a
);

  logic [PHASE_W-1:0] phase_acc;
  logic [PHASE_W-1:0] tw_active;
  logic               sync_now;

`ifdef SINE_PHASE_SYNC_EN
  logic sync_pend;

  // A sync pulse coincident with the advance takes effect on that same round.
  assign sync_now = sync_pend | phase_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_pend <= 1'b0;
    end else if (advance) begin
      sync_pend <= 1'b0;
    end else if (phase_sync) begin
      sync_pend <= 1'b1;
    end
  end
`else
  assign sync_now = 1'b0;
`endif

  // The increment applied on an advance always uses the tw_active value held
  // before a coincident tw_load; the new word only affects later rounds.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_acc <= '0;
      tw_active <= '0;
    end else begin
      if (tw_load) begin
        tw_active <= tuning_word;
      end
      if (advance) begin
        phase_acc <= sync_now ? tw_active : phase_acc + tw_active;
      end
    end
  end

  // The round reads the pre-increment phase (or phase 0 on a sync).
  assign addr_a = sync_now ? '0 : phase_acc[PHASE_W-1 -: ADDR_W];

endmodule

// File: rtl/sine_lut_scheduler.sv
// rtl/sine_lut_scheduler.sv - three-phase sine sample scheduler over a single async-read ROM port
//
// Purpose : on each accepted sample_tick, reads the sine ROM at the accumulator
//           phase and at +1/3 and +2/3 of the address space, then presents the
//           three samples together with a one-cycle samples_valid pulse.
// Ports   : clk, rst                 - clock, synchronous active-high reset
//           enable                   - gates acceptance of new ticks
//           sample_tick              - pulse: start a read round
//           tuning_word, tw_load     - phase increment and its load strobe
//           phase_sync               - (only with `SINE_PHASE_SYNC_EN) phase restart request
//           rom_addr, rom_data       - ROM address (registered) and same-cycle read data
//           sample_a/b/c             - channel samples, held between rounds
//           samples_valid            - pulse when sample_a/b/c update
//           busy                     - round in progress
//           tick_overrun             - sticky: a tick arrived while busy
// Config  : `SINE_PHASE_SYNC_EN adds the phase_sync input.

module sine_lut_scheduler
  import sine_sched_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               sample_tick,
  input  logic [PHASE_W-1:0] tuning_word,
  input  logic               tw_load,
`ifdef SINE_PHASE_SYNC_EN
  input  logic               phase_sync,
`endif
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [DATA_W-1:0]  rom_data,
  output logic [DATA_W-1:0]  sample_a,
  output logic [DATA_W-1:0]  sample_b,
  output logic [DATA_W-1:0]  sample_c,
  output logic               samples_valid,
  output logic               busy,
  output logic               tick_overrun
);

  localparam logic [ADDR_W-1:0] OFS_B = ADDR_W'(ofs_b(ADDR_W));
  localparam logic [ADDR_W-1:0] OFS_C = ADDR_W'(ofs_c(ADDR_W));

  state_t              state;
  logic [ADDR_W-1:0]   addr_a;
  logic [ADDR_W-1:0]   base_addr;
  logic [DATA_W-1:0]   cap_a;
  logic [DATA_W-1:0]   cap_b;
  logic                advance;

  assign advance = (state == IDLE) && sample_tick && enable;

  sine_phase_acc #(
    .PHASE_W (PHASE_W),
    .ADDR_W  (ADDR_W)
  ) u_phase_acc (
    .clk         (clk),
    .rst         (rst),
`ifdef SINE_PHASE_SYNC_EN
    .phase_sync  (phase_sync),
`endif
    .tuning_word (tuning_word),
    .tw_load     (tw_load),
    .advance     (advance),
    .addr_a      (addr_a)
  );

  // base_addr keeps channel A's address for the whole round because the
  // accumulator has already moved on by the time B and C are addressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rom_addr      <= '0;
      base_addr     <= '0;
      cap_a         <= '0;
      cap_b         <= '0;
      sample_a      <= '0;
      sample_b      <= '0;
      sample_c      <= '0;
      samples_valid <= 1'b0;
      busy          <= 1'b0;
      tick_overrun  <= 1'b0;
    end else begin
      samples_valid <= 1'b0;

      // Ticks during a round are dropped regardless of enable.
      if (sample_tick && (state != IDLE)) begin
        tick_overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (advance) begin
            rom_addr  <= addr_a;
            base_addr <= addr_a;
            busy      <= 1'b1;
            state     <= RD_A;
          end
        end
        RD_A: begin
          cap_a    <= rom_data;
          rom_addr <= base_addr + OFS_B;
          state    <= RD_B;
        end
        RD_B: begin
          cap_b    <= rom_data;
          rom_addr <= base_addr + OFS_C;
          state    <= RD_C;
        end
        RD_C: begin
          sample_a      <= cap_a;
          sample_b      <= cap_b;
          sample_c      <= rom_data;
          samples_valid <= 1'b1;
          busy          <= 1'b0;
          state         <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sine_lut_scheduler.sv
// tb/tb_sine_lut_scheduler.sv - directed scoreboard bench for sine_lut_scheduler

module tb_sine_lut_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        sample_tick;
  logic [31:0] tuning_word;
  logic        tw_load;
`ifdef SINE_PHASE_SYNC_EN
  logic        phase_sync;
`endif
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic [7:0]  sample_a;
  logic [7:0]  sample_b;
  logic [7:0]  sample_c;
  logic        samples_valid;
  logic        busy;
  logic        tick_overrun;

  int vec  = 0;
  int errs = 0;
  int n_valid = 0;

  logic [23:0] exp_q[$];
  logic [31:0] m_phase;
  logic [31:0] m_tw;
  bit          m_pend;

  always #5 clk = ~clk;

  // Sine ROM stand-in: data is the address high byte, read asynchronously.
  assign rom_data = rom_addr[15:8];

  sine_lut_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .sample_tick   (sample_tick),
    .tuning_word   (tuning_word),
    .tw_load       (tw_load),
`ifdef SINE_PHASE_SYNC_EN
    .phase_sync    (phase_sync),
`endif
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .sample_a      (sample_a),
    .sample_b      (sample_b),
    .sample_c      (sample_c),
    .samples_valid (samples_valid),
    .busy          (busy),
    .tick_overrun  (tick_overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every valid pulse pops one expected sample triple.
  always @(negedge clk) begin
    if (samples_valid === 1'b1) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", {8'h0, sample_a, sample_b, sample_c}, 32'hFFFFFFFF);
      end else begin
        chk("samples_abc", {8'h0, sample_a, sample_b, sample_c}, {8'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_tw(input logic [31:0] tw);
    tw_load = 1'b1;
    tuning_word = tw;
    cyc();
    tw_load = 1'b0;
    m_tw = tw;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    m_phase = 32'h0;
    m_tw = 32'h0;
    m_pend = 1'b0;
  endtask

  // One full round started by a tick, 8-cycle tick period.
  task automatic do_round(input bit ld, input logic [31:0] tw_new, input bit sync, input bit drop_en);
    logic [15:0] a0, ab, ac;
    bit use_sync;
    use_sync = sync | m_pend;
    m_pend = 1'b0;
    a0 = use_sync ? 16'h0000 : m_phase[31:16];
    m_phase = use_sync ? m_tw : m_phase + m_tw;
    if (ld) m_tw = tw_new;
    ab = a0 + 16'h5555;
    ac = a0 + 16'hAAAA;
    sample_tick = 1'b1;
    tw_load = ld;
    tuning_word = tw_new;
`ifdef SINE_PHASE_SYNC_EN
    phase_sync = sync;
`endif
    cyc();
    sample_tick = 1'b0;
    tw_load = 1'b0;
`ifdef SINE_PHASE_SYNC_EN
    phase_sync = 1'b0;
`endif
    if (drop_en) enable = 1'b0;
    exp_q.push_back({a0[15:8], ab[15:8], ac[15:8]});
    chk("busy_round", busy, 1);
    chk("rom_addr_a", rom_addr, a0);
    cyc();
    chk("rom_addr_b", rom_addr, ab);
    cyc();
    chk("rom_addr_c", rom_addr, ac);
    cyc();
    chk("valid_t4", samples_valid, 1);
    chk("busy_end", busy, 0);
    enable = 1'b1;
    repeat (4) cyc();
  endtask

  int nv0;
  logic [15:0] oa, ob, oc;

  initial begin
    rst = 1'b1;
    enable = 1'b1;
    sample_tick = 1'b0;
    tuning_word = 32'h0;
    tw_load = 1'b0;
`ifdef SINE_PHASE_SYNC_EN
    phase_sync = 1'b0;
`endif
    m_phase = 32'h0;
    m_tw = 32'h0;
    m_pend = 1'b0;
    repeat (2) cyc();
    chk("rst_busy", busy, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_samples", {8'h0, sample_a, sample_b, sample_c}, 0);
    chk("rst_valid", samples_valid, 0);
    chk("rst_overrun", tick_overrun, 0);
    rst = 1'b0;
    cyc();

    // Basic: 0x0000/0x5555/0xAAAA then 0x0100-based round.
    load_tw(32'h01000000);
    do_round(0, 32'h0, 0, 0);
    do_round(0, 32'h0, 0, 0);
    chk("basic_sample_a", sample_a, 8'h01);
    chk("basic_sample_c", sample_c, 8'hAB);

    // Overrun: tick held for two cycles, second one dropped.
    oa = m_phase[31:16];
    ob = oa + 16'h5555;
    oc = oa + 16'hAAAA;
    m_phase = m_phase + m_tw;
    exp_q.push_back({oa[15:8], ob[15:8], oc[15:8]});
    nv0 = n_valid;
    sample_tick = 1'b1;
    cyc();
    cyc();
    sample_tick = 1'b0;
    chk("overrun_set", tick_overrun, 1);
    repeat (6) cyc();
    chk("overrun_one_valid", n_valid - nv0, 1);
    do_round(0, 32'h0, 0, 0);
    chk("overrun_sticky", tick_overrun, 1);

    // Reset asserted while in RD_B aborts the round.
    nv0 = n_valid;
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    m_phase = 32'h0;
    m_tw = 32'h0;
    m_pend = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_rom_addr", rom_addr, 0);
    chk("midrst_samples", {8'h0, sample_a, sample_b, sample_c}, 0);
    chk("midrst_valid", samples_valid, 0);
    chk("midrst_overrun", tick_overrun, 0);
    repeat (6) cyc();
    chk("midrst_no_valid", n_valid - nv0, 0);

    // Wrap: second round addrA 0xFFFF, B 0x5554, C 0xAAA9.
    load_tw(32'hFFFFFFFF);
    do_round(0, 32'h0, 0, 0);
    do_round(0, 32'h0, 0, 0);
    chk("wrap_sample_b", sample_b, 8'h55);

    // Tuning word loaded together with a tick: old word used for that step.
    do_reset();
    load_tw(32'h01000000);
    do_round(1, 32'h02000000, 0, 0);
    do_round(0, 32'h0, 0, 0);
    do_round(0, 32'h0, 0, 0);
    chk("tw_third_round_a", sample_a, 8'h03);

    // Enable low: tick ignored; enable dropped mid-round still completes.
    enable = 1'b0;
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    enable = 1'b1;
    chk("disabled_tick_busy", busy, 0);
    chk("disabled_tick_overrun", tick_overrun, 0);
    do_round(0, 32'h0, 0, 1);

`ifdef SINE_PHASE_SYNC_EN
    do_reset();
    load_tw(32'h01000000);
    repeat (5) do_round(0, 32'h0, 0, 0);
    phase_sync = 1'b1;
    m_pend = 1'b1;
    cyc();
    phase_sync = 1'b0;
    do_round(0, 32'h0, 0, 0);
    chk("sync_sample_a", sample_a, 8'h00);
    do_round(0, 32'h0, 0, 0);
    chk("sync_next_a", sample_a, 8'h01);
`endif

    repeat (2) cyc();
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
